// File: rtl/image_stream_loader.sv
// Double-buffered pixel source: N_BANKS images held in block RAM, streamed AXI-Stream style.
// Define IMG_STREAM_LOOP_EN to add the loop_mode port for back-to-back frame repetition.
module image_stream_loader #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned N_PIXELS   = 784,
  parameter int unsigned N_BANKS    = 2,
  localparam int unsigned AW = $clog2(N_PIXELS),
  localparam int unsigned BW = (N_BANKS > 1) ? $clog2(N_BANKS) : 1
) (
  input  logic                  s_axi_aclk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [BW-1:0]         wr_bank,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  start,
  input  logic [BW-1:0]         rd_bank,
  input  logic                  abort,
  output logic [DATA_WIDTH-1:0] x_tdata,
  output logic                  x_tvalid,
  input  logic                  x_tready,
  output logic                  x_tlast,
  output logic                  busy,
`ifdef IMG_STREAM_LOOP_EN
  input  logic                  loop_mode,
`endif
  output logic                  done
);

  localparam int unsigned DEPTH = N_BANKS * N_PIXELS;
  localparam int unsigned MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(N_PIXELS - 1);
`ifdef IMG_STREAM_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StPrime, StStream} state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  start_q;
  logic [BW-1:0]         bank_q;
  logic [AW-1:0]         rd_addr_q;
  logic                  rd_fin_q;
  logic [DATA_WIDTH-1:0] ram_q;
  logic                  ram_v_q, ram_last_q;
  logic [DATA_WIDTH-1:0] out_data_q, sk_data_q;
  logic                  out_v_q, out_last_q, sk_v_q, sk_last_q;
  logic                  busy_q, done_q;

  logic                  start_edge, bank_ok, wr_ok, pop, last_pop, loop_on, issue;
  logic [1:0]            pending;
  logic [MW-1:0]         wr_idx, rd_idx;

`ifdef IMG_STREAM_LOOP_EN
  assign loop_on = loop_mode;
`else
  assign loop_on = 1'b0;
`endif

  assign start_edge = start & ~start_q;
  assign bank_ok    = 32'(rd_bank) < N_BANKS;
  assign wr_ok      = wr_en && (32'(wr_addr) < N_PIXELS) && (32'(wr_bank) < N_BANKS);
  assign wr_idx     = MW'(32'(wr_bank) * N_PIXELS + 32'(wr_addr));
  assign rd_idx     = MW'(32'(bank_q) * N_PIXELS + 32'(rd_addr_q));
  assign pop        = out_v_q & x_tready;
  assign last_pop   = pop & out_last_q & (state_q == StStream);

  // Words held or landing next edge, minus the one leaving now. A new read lands two edges
  // later, so it is only issued when at most one word would then sit in the out/skid pair.
  assign pending = 2'(out_v_q) + 2'(sk_v_q) + 2'(ram_v_q) - 2'(pop);
  assign issue   = ((state_q == StPrime) || (state_q == StStream)) && !rd_fin_q &&
                   (pending <= 2'd1);

  // Read-before-write: a same-address collision returns the old word.
  always_ff @(posedge s_axi_aclk) begin
    if (wr_ok) mem[wr_idx] <= wr_data;
    if (issue) ram_q <= mem[rd_idx];
  end

  always_ff @(posedge s_axi_aclk) begin
    if (rst) begin
      state_q    <= StIdle;
      start_q    <= 1'b0;
      bank_q     <= '0;
      rd_addr_q  <= '0;
      rd_fin_q   <= 1'b0;
      ram_v_q    <= 1'b0;
      ram_last_q <= 1'b0;
      out_v_q    <= 1'b0;
      out_last_q <= 1'b0;
      out_data_q <= '0;
      sk_v_q     <= 1'b0;
      sk_last_q  <= 1'b0;
      sk_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      start_q <= start;
      done_q  <= 1'b0;
      if (abort) begin
        state_q    <= StIdle;
        busy_q     <= 1'b0;
        rd_fin_q   <= 1'b0;
        ram_v_q    <= 1'b0;
        out_v_q    <= 1'b0;
        out_last_q <= 1'b0;
        sk_v_q     <= 1'b0;
      end else begin
        ram_v_q <= issue;
        if (issue) begin
          ram_last_q <= (rd_addr_q == LAST_ADDR);
          if (rd_addr_q == LAST_ADDR) begin
            if (LOOP_EN) rd_addr_q <= '0;
            else         rd_fin_q  <= 1'b1;
          end else begin
            rd_addr_q <= rd_addr_q + AW'(1);
          end
        end

        // Output register is the head; the skid only fills while the head is stalled.
        if (pop || !out_v_q) begin
          if (sk_v_q) begin
            out_data_q <= sk_data_q;
            out_last_q <= sk_last_q;
            sk_v_q     <= ram_v_q;
            sk_last_q  <= ram_v_q & ram_last_q;
            if (ram_v_q) sk_data_q <= ram_q;
          end else begin
            out_v_q    <= ram_v_q;
            out_last_q <= ram_v_q & ram_last_q;
            if (ram_v_q) out_data_q <= ram_q;
          end
        end else if (ram_v_q) begin
          sk_v_q    <= 1'b1;
          sk_last_q <= ram_last_q;
          sk_data_q <= ram_q;
        end

        unique case (state_q)
          StIdle: begin
            if (start_edge && bank_ok) begin
              state_q   <= StPrime;
              busy_q    <= 1'b1;
              bank_q    <= rd_bank;
              rd_addr_q <= '0;
              rd_fin_q  <= 1'b0;
            end
          end
          StPrime: state_q <= StStream;
          StStream: begin
            if (last_pop) begin
              done_q <= 1'b1;
              // Leaving: anything still buffered is prefetch of a frame that will not be sent.
              if (!loop_on) begin
                state_q    <= StIdle;
                busy_q     <= 1'b0;
                ram_v_q    <= 1'b0;
                out_v_q    <= 1'b0;
                out_last_q <= 1'b0;
                sk_v_q     <= 1'b0;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign x_tdata  = out_data_q;
  assign x_tvalid = out_v_q;
  assign x_tlast  = out_last_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_image_stream_loader.sv
// Bench for image_stream_loader: frame vector table plus abort, reset and loop sequences,
// with a scoreboard queue of expected beats checked at every handshake.
module tb_image_stream_loader;

  localparam int NPIX = 784;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  typedef struct {
    int bank;
    int pct;
    bit hammer;
    int exp_beats;
    int exp_dones;
  } frame_vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [0:0]  wr_bank = '0;
  logic [9:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        start = 1'b0;
  logic [0:0]  rd_bank = '0;
  logic        abort = 1'b0;
  logic [31:0] x_tdata;
  logic        x_tvalid;
  logic        x_tready = 1'b0;
  logic        x_tlast;
  logic        busy;
  logic        done;
  logic        loop_mode_v = 1'b0;

  image_stream_loader #(
    .DATA_WIDTH(32),
    .N_PIXELS  (NPIX),
    .N_BANKS   (2)
  ) dut (
    .s_axi_aclk(clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_bank   (wr_bank),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .start     (start),
    .rd_bank   (rd_bank),
    .abort     (abort),
    .x_tdata   (x_tdata),
    .x_tvalid  (x_tvalid),
    .x_tready  (x_tready),
    .x_tlast   (x_tlast),
    .busy      (busy),
`ifdef IMG_STREAM_LOOP_EN
    .loop_mode (loop_mode_v),
`endif
    .done      (done)
  );

  always #5 clk = ~clk;

  logic [31:0] img [2][NPIX];
  beat_t       exp_q [$];
  int          n_vec = 0;
  int          n_err = 0;
  int          beats = 0;
  int          dones = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic        prev_last = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Samples the current cycle (inputs already driven), scores any handshake, then advances.
  task automatic tick();
    beat_t e;
    if (x_tvalid === 1'b1 && x_tready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL spurious_beat: got data %0h, required no beat", x_tdata);
      end else begin
        e = exp_q.pop_front();
        check("tdata", x_tdata, e.data);
        check("tlast", 32'(x_tlast), 32'(e.last));
      end
      beats++;
    end
    if (prev_stall) begin
      check("stall_valid", 32'(x_tvalid), 32'd1);
      check("stall_data", x_tdata, prev_data);
      check("stall_last", 32'(x_tlast), 32'(prev_last));
    end
    prev_stall = (x_tvalid === 1'b1) && !x_tready && !abort && !rst;
    prev_data  = x_tdata;
    prev_last  = x_tlast;
    if (done === 1'b1) begin
      dones++;
      check("busy_at_done", 32'(busy), loop_mode_v ? 32'd1 : 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input int bank);
    for (int i = 0; i < NPIX; i++) exp_q.push_back('{data: img[bank][i], last: (i == NPIX - 1)});
  endtask

  task automatic run_frame(input frame_vec_t v);
    int cyc;
    push_frame(v.bank);
    beats   = 0;
    dones   = 0;
    rd_bank = 1'(v.bank);
    start   = 1'b1;
    tick();
    start = 1'b0;
    cyc   = 0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_valid", 32'(x_tvalid), 32'd0);
    tick();
    cyc++;
    check("prime_valid", 32'(x_tvalid), 32'd0);
    tick();
    cyc++;
    check("first_valid", 32'(x_tvalid), 32'd1);
    check("first_data", x_tdata, img[v.bank][0]);
    while (done !== 1'b1 && cyc < NPIX * 20) begin
      x_tready = (v.pct >= 100) ? 1'b1 : ($urandom_range(99) < 32'(v.pct));
      if (v.hammer) begin
        wr_en   = 1'b1;
        wr_bank = 1'b0;
        wr_addr = 10'(cyc % NPIX);
        wr_data = $urandom;
        img[0][cyc % NPIX] = wr_data;
        start   = (cyc >= 300 && cyc < 303);
      end
      tick();
      cyc++;
    end
    wr_en = 1'b0;
    start = 1'b0;
    check("frame_done", 32'(done), 32'd1);
    if (v.pct >= 100) check("frame_cycles", 32'(cyc), 32'(NPIX + 2));
    x_tready = 1'b1;
    repeat (6) tick();
    check("frame_beats", 32'(beats), 32'(v.exp_beats));
    check("frame_dones", 32'(dones), 32'(v.exp_dones));
    check("frame_queue", 32'(exp_q.size()), 32'd0);
    check("frame_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    frame_vec_t vecs [5];
    int cyc;
    vecs[0] = '{bank: 0, pct: 100, hammer: 1'b0, exp_beats: NPIX, exp_dones: 1};
    vecs[1] = '{bank: 0, pct: 50,  hammer: 1'b0, exp_beats: NPIX, exp_dones: 1};
    vecs[2] = '{bank: 1, pct: 100, hammer: 1'b0, exp_beats: NPIX, exp_dones: 1};
    vecs[3] = '{bank: 1, pct: 100, hammer: 1'b1, exp_beats: NPIX, exp_dones: 1};
    vecs[4] = '{bank: 1, pct: 40,  hammer: 1'b1, exp_beats: NPIX, exp_dones: 1};

    repeat (3) tick();
    check("rst_valid", 32'(x_tvalid), 32'd0);
    check("rst_last", 32'(x_tlast), 32'd0);
    check("rst_data", x_tdata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b0;

    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < NPIX; i++) begin
        wr_en     = 1'b1;
        wr_bank   = 1'(b);
        wr_addr   = 10'(i);
        wr_data   = (b == 0) ? 32'(i * 3) : ~32'(i);
        img[b][i] = wr_data;
        tick();
      end
    end
    // Out-of-range pixel index must not alias into the neighbouring bank.
    wr_bank = 1'b0;
    wr_addr = 10'd1000;
    wr_data = 32'hdead_beef;
    tick();
    wr_en = 1'b0;

    for (int n = 0; n < 5; n++) run_frame(vecs[n]);

    // Abort at beat 400, then a clean full frame.
    push_frame(0);
    beats    = 0;
    dones    = 0;
    rd_bank  = 1'b0;
    x_tready = 1'b1;
    start    = 1'b1;
    tick();
    start = 1'b0;
    cyc   = 0;
    while (beats < 400 && cyc < 2000) begin
      tick();
      cyc++;
    end
    check("abort_reach", 32'(beats), 32'd400);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_valid", 32'(x_tvalid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    exp_q.delete();
    repeat (8) tick();
    check("abort_no_done", 32'(dones), 32'd0);
    run_frame(vecs[0]);

    // Reset mid-frame with start held high across release: exactly one new frame.
    push_frame(1);
    rd_bank = 1'b1;
    start   = 1'b1;
    tick();
    start = 1'b0;
    repeat (200) tick();
    rst   = 1'b1;
    start = 1'b1;
    tick();
    check("midrst_valid", 32'(x_tvalid), 32'd0);
    check("midrst_last", 32'(x_tlast), 32'd0);
    check("midrst_data", x_tdata, 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    tick();
    exp_q.delete();
    rst = 1'b0;
    push_frame(1);
    beats = 0;
    dones = 0;
    tick();
    cyc = 0;
    check("relrst_busy", 32'(busy), 32'd1);
    while (done !== 1'b1 && cyc < NPIX * 4) begin
      tick();
      cyc++;
    end
    check("relrst_cycles", 32'(cyc), 32'(NPIX + 2));
    repeat (12) tick();
    check("relrst_beats", 32'(beats), 32'(NPIX));
    check("relrst_dones", 32'(dones), 32'd1);
    check("relrst_idle", 32'(busy), 32'd0);
    start = 1'b0;
    tick();

`ifdef IMG_STREAM_LOOP_EN
    // Loop for 2.5 frames: three back-to-back frames with no gap, then stop.
    for (int f = 0; f < 3; f++) push_frame(0);
    beats       = 0;
    dones       = 0;
    loop_mode_v = 1'b1;
    rd_bank     = 1'b0;
    start       = 1'b1;
    tick();
    start = 1'b0;
    cyc   = 0;
    while (dones < 3 && cyc < NPIX * 8) begin
      if (beats >= 2 * NPIX + NPIX / 2) loop_mode_v = 1'b0;
      tick();
      cyc++;
    end
    check("loop_cycles", 32'(cyc), 32'(3 * NPIX + 3));
    repeat (10) tick();
    check("loop_beats", 32'(beats), 32'(3 * NPIX));
    check("loop_dones", 32'(dones), 32'd3);
    check("loop_idle", 32'(busy), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/image_stream_loader.md
# image_stream_loader

Parametrised, double-buffered pixel source for the inference datapath. Holds `N_BANKS` images of `N_PIXELS` words each in internal block RAM, written through a simple write port. On a rising edge of `start` it streams the selected bank to the first layer over an AXI-Stream style `x_*` interface. The stream carries full backpressure support and `x_tlast`, and sustains one beat per cycle.

## Interface
- `DATA_WIDTH`, 32: width of each pixel word and of `x_tdata`.
- `N_PIXELS`, 784: words per image (≥2); `AW = $clog2(N_PIXELS)` derived.
- `N_BANKS`, 2: image banks (power of two, ≥1); `BW = max(1, $clog2(N_BANKS))` derived.
- `s_axi_aclk`  in  1  single clock, all logic rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  write strobe for the image buffer.
- `wr_bank`  in  BW  bank to write.
- `wr_addr`  in  AW  pixel index to write; values ≥ `N_PIXELS` are ignored.
- `wr_data`  in  DATA_WIDTH  pixel value.
- `start`  in  1  level input; its rising edge requests a frame.
- `rd_bank`  in  BW  bank to stream; sampled on the accepted start edge.
- `abort`  in  1  cancels the frame in progress.
- `x_tdata`  out  DATA_WIDTH  pixel word.
- `x_tvalid`  out  1  beat valid.
- `x_tready`  in  1  consumer ready.
- `x_tlast`  out  1  high on pixel `N_PIXELS-1`.
- `busy`  out  1  high from start acceptance until the last handshake, or until abort.
- `done`  out  1  one-cycle pulse after the final handshake of a frame.
- `loop_mode`  in  1  exists only with `IMG_STREAM_LOOP_EN`.

## Operation
- Start edge detect: `start_q` register, reset 0; `start_edge = start & ~start_q`. A `start` held high while `rst` is released therefore yields one edge.
- FSM states: IDLE, PRIME, STREAM.
  - IDLE: `start_edge` with `rd_bank < N_BANKS` → latch bank, issue read of addr 0, go to PRIME, assert `busy`. Out-of-range bank: edge ignored.
  - PRIME: one cycle for the 1-cycle RAM latency → STREAM.
  - STREAM: exit on the handshake of the `x_tlast` beat → IDLE, `done` pulse.
- Read pipeline:
  - Read address counter, 1-cycle-latency RAM, output register, one-entry skid buffer.
  - A read is issued only when it is guaranteed a slot, so no word is lost or duplicated under any `x_tready` pattern.
  - Address stride is 1 word; the counter stops at `N_PIXELS-1` with no wrap.
- `start_edge` while `busy` is ignored. No queuing.
- Writes:
  - Allowed at any time. Writes to a bank other than the streaming one are safe (double buffering).
  - A write to the streaming bank has an undefined data effect but must not disturb the handshake, the beat count or `x_tlast`.
  - Same-address read/write collision returns the old data.
- `abort` (any state): next cycle `x_tvalid=0`, `busy=0`, FSM=IDLE, skid emptied, no `done`. `abort` has priority over a coincident `start_edge`.
- `rst` mid-frame: identical to `abort`. Buffer contents are not cleared.

## Timing
- Reset values:
  - `x_tvalid=0`, `x_tlast=0`, `x_tdata=0`, `busy=0`, `done=0`.
  - FSM=IDLE, counters 0.
- Start latency: edge sampled at clock edge k → `busy=1` after k → first `x_tvalid=1` after k+2, carrying pixel 0.
- With `x_tready` held high: one beat per cycle, last beat after k+1+`N_PIXELS`, `done` high for the cycle after k+2+`N_PIXELS`.
- AXI-Stream rules:
  - While `x_tvalid & ~x_tready`, `x_tdata` and `x_tlast` stay stable and `x_tvalid` stays high.
  - `x_tvalid` never depends combinationally on `x_tready`.
- `x_tready` may toggle every cycle. Zero bubbles once `x_tready` returns high with data buffered.
- `busy` falls in the same cycle `done` rises.

## Configuration
- `IMG_STREAM_LOOP_EN` defined:
  - The `loop_mode` port exists.
  - If `loop_mode=1` at the `x_tlast` handshake, the frame restarts at pixel 0 of the latched bank with no bubble: pixel 0 follows the last pixel on the next cycle when ready.
  - `done` still pulses each frame; `busy` stays high.
  - Exit by deasserting `loop_mode` (takes effect at the next `x_tlast` handshake) or by `abort`.
- Not defined: no `loop_mode` port; the FSM always returns to IDLE after one frame.

## Test plan
- Fill bank 0 with `i*3`, bank 1 with `~i` (`N_PIXELS=784`); start bank 0 with `x_tready=1` → 784 beats `0,3,…,2349`; first valid 2 cycles after the edge; `x_tlast` only on beat 783; one `done`.
- Same frame with pseudo-random `x_tready` (50%) → identical ordered sequence, stable data during stalls, no drops or duplicates.
- Stream bank 1 while rewriting bank 0 every cycle → bank 1 output exactly `~i`; `start_edge` mid-frame ignored.
- `abort` at beat 400 → `x_tvalid=0` next cycle, no `done`; new start → full 784-beat frame from pixel 0.
- `rst` pulse mid-frame, and `start` held high across reset release → all outputs at reset values; exactly one frame after reset.
- `IMG_STREAM_LOOP_EN`, `loop_mode=1` for 2.5 frames then 0 → back-to-back frames with no gap, 3 `done` pulses, stop after the third `x_tlast`.
